set_mode_ctrl: RTL and testbench

SET_MODE_CTRL -- requirements
Module: set_mode_ctrl

---
 rtl/clock_pkg.sv | 36 +++
 rtl/set_mode_ctrl_if.sv | 21 ++
 rtl/btn_debounce.sv | 65 ++++++
 rtl/set_mode_ctrl.sv | 158 +++++++++++++++
 tb/tb_set_mode_ctrl.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/clock_pkg.sv
// Shared types and constants for the clock-setting control slice.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } mode_t;

  localparam logic [3:0] HOUR_MASK = 4'b1100;
  localparam logic [3:0] MIN_MASK  = 4'b0011;

  // Mode sequence on a set-button release; the unused encoding falls back to RUN.
  function automatic mode_t next_mode(input mode_t m);
    mode_t n;
    case (m)
      RUN:      n = SET_HOUR;
      SET_HOUR: n = SET_MIN;
      SET_MIN:  n = RUN;
      default:  n = RUN;
    endcase
    return n;
  endfunction

  // Digits being edited blank during the "on" half of the blink.
  function automatic logic [3:0] blank_for(input mode_t m, input logic phase);
    logic [3:0] mask;
    case (m)
      SET_HOUR: mask = phase ? HOUR_MASK : 4'b0000;
      SET_MIN:  mask = phase ? MIN_MASK  : 4'b0000;
      default:  mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/set_mode_ctrl_if.sv
// Button/tick inputs and timekeeper/display outputs of the set-mode controller.
interface set_mode_ctrl_if;
  logic       btn_set;
  logic       btn_inc;
  logic       tick_1hz;
  logic [1:0] mode;
  logic       inc_hour;
  logic       inc_min;
  logic       clear_sec;
  logic [3:0] blank_mask;

  modport master (
    output btn_set, btn_inc, tick_1hz,
    input  mode, inc_hour, inc_min, clear_sec, blank_mask
  );

  modport slave (
    input  btn_set, btn_inc, tick_1hz,
    output mode, inc_hour, inc_min, clear_sec, blank_mask
  );
endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus counting debouncer; emits registered one-cycle
// pulses on each debounced rising and falling edge.
module btn_debounce #(
  parameter int DEB_CYC = 180000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(DEB_CYC + 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          deb_r;
  logic          deb_d_r;
  logic          rise_r;
  logic          fall_r;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic          deb_nxt_s;

  // Count consecutive disagreeing cycles; flip the level when the run completes.
  always_comb begin
    cnt_nxt_s = cnt_r;
    deb_nxt_s = deb_r;
    if (sync2_r != deb_r) begin
      if (cnt_r == CW'(DEB_CYC - 1)) begin
        deb_nxt_s = sync2_r;
        cnt_nxt_s = {CW{1'b0}};
      end else begin
        cnt_nxt_s = cnt_r + CW'(1);
      end
    end else begin
      cnt_nxt_s = {CW{1'b0}};
    end
  end

  // Synchronizer, debounce state and registered edge pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      cnt_r   <= {CW{1'b0}};
      deb_r   <= 1'b0;
      deb_d_r <= 1'b0;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
      cnt_r   <= cnt_nxt_s;
      deb_r   <= deb_nxt_s;
      deb_d_r <= deb_r;
      rise_r  <= deb_r & ~deb_d_r;
      fall_r  <= ~deb_r & deb_d_r;
    end
  end

  assign rise = rise_r;
  assign fall = fall_r;

endmodule

// File: rtl/set_mode_ctrl.sv
// Clock set-mode controller: cycles RUN/SET_HOUR/SET_MIN on set-button release,
// issues increment pulses with auto-repeat, blinks the edited digits and
// falls back to RUN after an idle timeout.
module set_mode_ctrl
  import clock_pkg::*;
#(
  parameter int DEB_CYC       = 180000,
  parameter int REPEAT_DELAY  = 6000000,
  parameter int REPEAT_PERIOD = 2400000,
  parameter int TIMEOUT_S     = 10
) (
  input logic            clk,
  input logic            rst,
  set_mode_ctrl_if.slave bus
);

  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW      = $clog2(REP_MAX + 1);
  localparam int TW      = $clog2(TIMEOUT_S + 1);

  logic set_rise_s;
  logic set_fall_s;
  logic inc_rise_s;
  logic inc_fall_s;

  mode_t         mode_r;
  logic          hold_r;
  logic [RW-1:0] rep_cnt_r;
  logic [TW-1:0] tmo_cnt_r;
  logic          phase_r;
  logic          inc_hour_r;
  logic          inc_min_r;
  logic          clear_sec_r;
  logic [3:0]    blank_r;

  mode_t         mode_nxt_s;
  logic          hold_nxt_s;
  logic [RW-1:0] rep_nxt_s;
  logic [TW-1:0] tmo_nxt_s;
  logic          phase_nxt_s;
  logic          pulse_s;
  logic          press_s;
  logic          timeout_s;
  logic          mode_chg_s;

  btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_set (
    .clk  (clk),
    .rst  (rst),
    .btn  (bus.btn_set),
    .rise (set_rise_s),
    .fall (set_fall_s)
  );

  btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_inc (
    .clk  (clk),
    .rst  (rst),
    .btn  (bus.btn_inc),
    .rise (inc_rise_s),
    .fall (inc_fall_s)
  );

  // Next mode, timeout, auto-repeat and blink phase; a mode change outranks increments.
  always_comb begin
    mode_nxt_s  = mode_r;
    hold_nxt_s  = hold_r;
    rep_nxt_s   = rep_cnt_r;
    tmo_nxt_s   = tmo_cnt_r;
    phase_nxt_s = phase_r;
    pulse_s     = 1'b0;
    timeout_s   = 1'b0;
    press_s     = set_rise_s | inc_rise_s;

    // A press in the same cycle as the final tick restarts the idle window.
    if ((mode_r != RUN) && bus.tick_1hz && !press_s && (tmo_cnt_r == TW'(TIMEOUT_S - 1))) begin
      timeout_s = 1'b1;
    end else begin
      timeout_s = 1'b0;
    end

    if (timeout_s) begin
      mode_nxt_s = RUN;
    end else if (set_fall_s) begin
      mode_nxt_s = next_mode(mode_r);
    end else begin
      mode_nxt_s = mode_r;
    end
    mode_chg_s = (mode_nxt_s != mode_r);

    if (mode_chg_s || (mode_r == RUN) || press_s) begin
      tmo_nxt_s = {TW{1'b0}};
    end else if (bus.tick_1hz) begin
      tmo_nxt_s = tmo_cnt_r + TW'(1);
    end else begin
      tmo_nxt_s = tmo_cnt_r;
    end

    // Repeat only survives while the same press is held in the same set mode.
    if (mode_chg_s || (mode_r == RUN) || inc_fall_s) begin
      hold_nxt_s = 1'b0;
      rep_nxt_s  = {RW{1'b0}};
    end else if (inc_rise_s) begin
      pulse_s    = 1'b1;
      hold_nxt_s = 1'b1;
      rep_nxt_s  = RW'(REPEAT_DELAY - 1);
    end else if (hold_r) begin
      if (rep_cnt_r == {RW{1'b0}}) begin
        pulse_s   = 1'b1;
        rep_nxt_s = RW'(REPEAT_PERIOD - 1);
      end else begin
        rep_nxt_s = rep_cnt_r - RW'(1);
      end
    end else begin
      hold_nxt_s = 1'b0;
      rep_nxt_s  = {RW{1'b0}};
    end

    // Digits stay visible right after an increment so the new value shows.
    if (pulse_s) begin
      phase_nxt_s = 1'b0;
    end else if (bus.tick_1hz) begin
      phase_nxt_s = ~phase_r;
    end else begin
      phase_nxt_s = phase_r;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_r      <= RUN;
      hold_r      <= 1'b0;
      rep_cnt_r   <= {RW{1'b0}};
      tmo_cnt_r   <= {TW{1'b0}};
      phase_r     <= 1'b0;
      inc_hour_r  <= 1'b0;
      inc_min_r   <= 1'b0;
      clear_sec_r <= 1'b0;
      blank_r     <= 4'b0000;
    end else begin
      mode_r      <= mode_nxt_s;
      hold_r      <= hold_nxt_s;
      rep_cnt_r   <= rep_nxt_s;
      tmo_cnt_r   <= tmo_nxt_s;
      phase_r     <= phase_nxt_s;
      inc_hour_r  <= pulse_s & (mode_r == SET_HOUR);
      inc_min_r   <= pulse_s & (mode_r == SET_MIN);
      clear_sec_r <= pulse_s;
      blank_r     <= blank_for(mode_nxt_s, phase_nxt_s);
    end
  end

  assign bus.mode       = mode_r;
  assign bus.inc_hour   = inc_hour_r;
  assign bus.inc_min    = inc_min_r;
  assign bus.clear_sec  = clear_sec_r;
  assign bus.blank_mask = blank_r;

endmodule

// File: tb/tb_set_mode_ctrl.sv
// Bench for set_mode_ctrl: directed scenarios plus random stimulus, every cycle
// compared against a time-based behavioural model.
module tb_set_mode_ctrl;

  localparam int DEB = 4;
  localparam int RD  = 20;
  localparam int RP  = 8;
  localparam int TO  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  set_mode_ctrl_if bus();

  set_mode_ctrl #(
    .DEB_CYC       (DEB),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP),
    .TIMEOUT_S     (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Model state: raw history, debounced levels, controller.
  bit       ms_r1, ms_r2, mi_r1, mi_r2;
  bit       ms_deb, mi_deb;
  int       ms_run, mi_run;
  bit [2:0] ms_h, mi_h;
  int       m_mode, m_ticks, m_next_rep;
  bit       m_hold, m_phase;
  bit       e_hour, e_min;
  logic [3:0] e_mask;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One button: level differing from the 2-cycle-delayed raw input for DEB cycles flips.
  task automatic deb_model(input bit raw, inout bit r1, inout bit r2, inout bit deb,
                           inout int run, inout bit [2:0] h);
    if (r2 != deb) begin
      run++;
      if (run == DEB) begin
        deb = r2;
        run = 0;
      end
    end else begin
      run = 0;
    end
    r2 = r1;
    r1 = raw;
    h  = {h[1:0], deb};
  endtask

  task automatic model_edge();
    bit s_rise, s_fall, i_rise, i_fall, press, tick, pulse, mchg;
    int old_mode, new_mode;
    if (rst) begin
      {ms_r1, ms_r2, mi_r1, mi_r2, ms_deb, mi_deb} = '0;
      ms_run = 0; mi_run = 0; ms_h = '0; mi_h = '0;
      m_mode = 0; m_ticks = 0; m_next_rep = 0; m_hold = 0; m_phase = 0;
      e_hour = 0; e_min = 0; e_mask = 4'b0000;
      return;
    end
    // Debounced edges become visible to the controller two cycles after they happen.
    s_rise = ms_h[1] & !ms_h[2];
    s_fall = !ms_h[1] & ms_h[2];
    i_rise = mi_h[1] & !mi_h[2];
    i_fall = !mi_h[1] & mi_h[2];
    tick   = bus.tick_1hz;
    press  = s_rise | i_rise;
    old_mode = m_mode;
    new_mode = m_mode;
    if (m_mode != 0 && tick && !press && (m_ticks + 1 == TO)) new_mode = 0;
    else if (s_fall) new_mode = (m_mode + 1) % 3;
    mchg  = (new_mode != old_mode);
    pulse = 0;
    if (mchg || old_mode == 0 || i_fall) begin
      m_hold = 0;
    end else if (i_rise) begin
      pulse = 1; m_hold = 1; m_next_rep = cyc + RD;
    end else if (m_hold && cyc == m_next_rep) begin
      pulse = 1; m_next_rep = cyc + RP;
    end
    if (mchg || old_mode == 0 || press) m_ticks = 0;
    else if (tick) m_ticks++;
    if (pulse) m_phase = 0;
    else if (tick) m_phase = !m_phase;
    m_mode = new_mode;
    e_hour = pulse && old_mode == 1;
    e_min  = pulse && old_mode == 2;
    if (m_mode == 1 && m_phase) e_mask = 4'b1100;
    else if (m_mode == 2 && m_phase) e_mask = 4'b0011;
    else e_mask = 4'b0000;
    deb_model(bus.btn_set, ms_r1, ms_r2, ms_deb, ms_run, ms_h);
    deb_model(bus.btn_inc, mi_r1, mi_r2, mi_deb, mi_run, mi_h);
  endtask

  // One clock: model takes the sampled inputs, outputs are compared 1 time unit later.
  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    chk("mode",       bus.mode,       m_mode);
    chk("inc_hour",   bus.inc_hour,   e_hour);
    chk("inc_min",    bus.inc_min,    e_min);
    chk("clear_sec",  bus.clear_sec,  e_hour | e_min);
    chk("blank_mask", bus.blank_mask, e_mask);
  endtask

  task automatic press_set();
    bus.btn_set = 1'b1;
    repeat (20) step();
    bus.btn_set = 1'b0;
    repeat (20) step();
  endtask

  initial begin
    int start, rel, cnt;
    logic [1:0] prev;
    int times[$];
    int exp_t[5];
    exp_t[0] = 7; exp_t[1] = 27; exp_t[2] = 35; exp_t[3] = 43; exp_t[4] = 51;
    bus.btn_set = 1'b0; bus.btn_inc = 1'b0; bus.tick_1hz = 1'b0;
    #1;

    // Reset state
    repeat (3) step();
    chk("rst_mode", bus.mode, 0);
    chk("rst_blank", bus.blank_mask, 0);
    rst = 1'b0;
    repeat (5) step();

    // Set-button cycling: mode 1, 2, 0, each 7 cycles after release
    for (int k = 0; k < 3; k++) begin
      bus.btn_set = 1'b1;
      repeat (20) step();
      prev = bus.mode;
      bus.btn_set = 1'b0;
      start = cyc + 1;
      rel = -1;
      for (int j = 0; j < 20; j++) begin
        step();
        if (rel < 0 && bus.mode != prev) rel = cyc - start;
      end
      chk("set_adv_time", rel, 7);
      chk("set_adv_mode", bus.mode, (k + 1) % 3);
    end

    // Auto-repeat in SET_MIN
    press_set();
    press_set();
    bus.btn_inc = 1'b1;
    start = cyc + 1;
    cnt = 0;
    for (int j = 0; j < 80; j++) begin
      if (j == 50) bus.btn_inc = 1'b0;
      step();
      if (bus.inc_min) times.push_back(cyc - start);
      if (bus.inc_hour) cnt++;
    end
    chk("rep_count", times.size(), 5);
    for (int j = 0; j < 5; j++) begin
      if (j < times.size()) chk("rep_time", times[j], exp_t[j]);
    end
    chk("rep_no_hour", cnt, 0);

    // Glitches in SET_HOUR, clean press in RUN
    press_set();
    press_set();
    cnt = 0;
    for (int j = 0; j < 50; j++) begin
      bus.btn_inc = (j < 40) && ((j % 5) < 2);
      step();
      if (bus.inc_hour || bus.inc_min) cnt++;
    end
    chk("glitch_pulses", cnt, 0);
    press_set();
    press_set();
    cnt = 0;
    bus.btn_inc = 1'b1;
    for (int j = 0; j < 60; j++) begin
      if (j == 40) bus.btn_inc = 1'b0;
      step();
      if (bus.inc_hour || bus.inc_min) cnt++;
    end
    chk("run_pulses", cnt, 0);

    // Blink and timeout in SET_HOUR
    press_set();
    for (int k = 0; k < 3; k++) begin
      repeat (9) step();
      bus.tick_1hz = 1'b1;
      step();
      bus.tick_1hz = 1'b0;
      if (k == 0) chk("blink_on", bus.blank_mask, 4'b1100);
      if (k == 1) chk("blink_off", bus.blank_mask, 4'b0000);
      if (k < 2) chk("tmo_hold_mode", bus.mode, 1);
      else chk("tmo_exit_mode", bus.mode, 0);
    end
    repeat (5) step();

    // Mode change cancels a held repeat
    press_set();
    bus.btn_inc = 1'b1;
    repeat (30) step();
    bus.btn_set = 1'b1;
    repeat (20) step();
    bus.btn_set = 1'b0;
    prev = bus.mode;
    cnt = 0;
    rel = 0;
    for (int j = 0; j < 60; j++) begin
      step();
      if (bus.mode != prev) rel = 1;
      if (rel != 0 && (bus.inc_hour || bus.inc_min)) cnt++;
    end
    chk("cancel_mode", bus.mode, 2);
    chk("cancel_pulses", cnt, 0);
    bus.btn_inc = 1'b0;
    repeat (20) step();
    bus.btn_inc = 1'b1;
    cnt = 0;
    repeat (20) begin
      step();
      if (bus.inc_min) cnt++;
    end
    chk("repress_pulses", cnt, 1);
    bus.btn_inc = 1'b0;
    repeat (20) step();

    // Reset mid-repeat with both buttons held
    bus.btn_inc = 1'b1;
    bus.btn_set = 1'b1;
    repeat (25) step();
    rst = 1'b1;
    step();
    chk("midrst_mode", bus.mode, 0);
    chk("midrst_pulse", {bus.inc_hour, bus.inc_min, bus.clear_sec}, 0);
    chk("midrst_blank", bus.blank_mask, 0);
    repeat (2) step();
    rst = 1'b0;
    cnt = 0;
    repeat (30) begin
      step();
      if (bus.inc_hour || bus.inc_min || bus.clear_sec) cnt++;
    end
    chk("postrst_pulses", cnt, 0);
    bus.btn_inc = 1'b0;
    bus.btn_set = 1'b0;
    repeat (20) step();

    // Random stimulus against the model
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 29) == 0) bus.btn_set = ~bus.btn_set;
      if ($urandom_range(0, 19) == 0) bus.btn_inc = ~bus.btn_inc;
      bus.tick_1hz = ($urandom_range(0, 24) == 0);
      rst = ($urandom_range(0, 799) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
